udivrem: RTL

//  Iterative radix-2 restoring divider: quotient and remainder of two DWIDTH-bit operands.

---
 rtl/udivrem_pkg.sv | 26 ++
 rtl/udivrem_step.sv | 29 ++
 rtl/udivrem.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/udivrem_pkg.sv
// ============================================================================
// udivrem_pkg : shared types and constants for the udivrem restoring divider
// Revision    : 1.0
// ============================================================================
`default_nettype none

package udivrem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the divide-by-zero quotient constant covers.
    localparam int MAX_DWIDTH = 64;
    localparam logic [MAX_DWIDTH-1:0] DIV0_QUOTIENT = '1;

    // Iteration counter width: must hold 0 .. width-1.
    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/udivrem_step.sv
// ============================================================================
// udivrem_step : one combinational restoring-division iteration
// Revision     : 1.0
// ============================================================================
`default_nettype none

module udivrem_step #(
    parameter int DWIDTH = 16
) (
    input  logic [DWIDTH:0]   i_rem,
    input  logic [DWIDTH-1:0] i_divisor,
    input  logic              i_bit,
    output logic [DWIDTH:0]   o_rem,
    output logic              o_qbit
);

    logic [DWIDTH:0] w_shifted;
    logic [DWIDTH:0] w_diff;

    assign w_shifted = {i_rem[DWIDTH-1:0], i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};

    // A set top bit means the shifted value overflowed past any divisor.
    assign o_qbit = i_rem[DWIDTH] | ~w_diff[DWIDTH];
    assign o_rem  = o_qbit ? w_diff : w_shifted;

endmodule

`default_nettype wire

// File: rtl/udivrem.sv
// ============================================================================
// udivrem : iterative radix-2 restoring divider, one quotient bit per clock
//           Optional two's complement operation via `define UDIVREM_SIGNED_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module udivrem
    import udivrem_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              sclr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] quotient,
    output logic [DWIDTH-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CW = count_width(DWIDTH);

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic [DWIDTH:0]   r_rem;
    logic [DWIDTH-1:0] r_dvd;
    logic [DWIDTH-1:0] r_dsr;
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_quotient;
    logic [DWIDTH-1:0] r_remainder;
    logic              r_dbz;

    logic [DWIDTH:0]   w_rem_next;
    logic              w_qbit;
    logic [DWIDTH-1:0] w_q_final;
    logic [DWIDTH-1:0] w_r_final;
    logic [DWIDTH-1:0] w_dvd_load;
    logic [DWIDTH-1:0] w_dsr_load;
    logic [DWIDTH-1:0] w_res_q;
    logic [DWIDTH-1:0] w_res_r;
    logic              w_last;

    udivrem_step #(
        .DWIDTH (DWIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_dsr),
        .i_bit     (r_dvd[DWIDTH-1]),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // The dividend register doubles as the quotient shift register.
    assign w_q_final = {r_dvd[DWIDTH-2:0], w_qbit};
    assign w_r_final = w_rem_next[DWIDTH-1:0];
    assign w_last    = (r_count == CW'(DWIDTH - 1));

`ifdef UDIVREM_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    always_comb begin
        w_dvd_load = dividend[DWIDTH-1] ? (~dividend + 1'b1) : dividend;
        w_dsr_load = divisor[DWIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        w_res_q    = r_neg_q ? (~w_q_final + 1'b1) : w_q_final;
        w_res_r    = r_neg_r ? (~w_r_final + 1'b1) : w_r_final;
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_neg_q <= dividend[DWIDTH-1] ^ divisor[DWIDTH-1];
            r_neg_r <= dividend[DWIDTH-1];
        end
    end
`else
    always_comb begin
        w_dvd_load = dividend;
        w_dsr_load = divisor;
        w_res_q    = w_q_final;
        w_res_r    = w_r_final;
    end
`endif

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvd   <= w_dvd_load;
                        r_dsr   <= w_dsr_load;
                        r_rem   <= '0;
                        r_count <= '0;
                        if (divisor == '0) begin
                            r_quotient  <= DIV0_QUOTIENT[DWIDTH-1:0];
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem   <= w_rem_next;
                    r_dvd   <= w_q_final;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_quotient  <= w_res_q;
                        r_remainder <= w_res_r;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
